sr_bank_arbiter: RTL and testbench
==================================

# sr_bank_arbiter

Shares one bank of NFF SR flip-flops between NREQ requesters, each issuing "set bit" or "reset bit" commands. Grants requesters round-robin and converts each accepted command into a single-cycle S or R pulse on exactly one flip-flop. Guarantees the forbidden S=R=1 input never reaches the bank. Optionally reads back Q to confirm each write. Sits between control logic and the SR_FF bank, whose clk and rst are shared with this block.

## Interface
- NREQ, 4, number of requesters (2..8)
- NFF, 8, number of SR flip-flops in the bank
- IDXW, $clog2(NFF), flip-flop index width
- clk  in  1  rising-edge clock, shared with the SR_FF bank
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  per-requester command valid
- req_op  in  NREQ  per-requester op: 1 = set, 0 = reset
- req_idx  in  NREQ*IDXW  per-requester target index, requester k in bits [k*IDXW +: IDXW]
- req_ready  out  NREQ  one-hot grant; the command transfers on valid&ready at a clk edge
- ff_s  out  NFF  S inputs to the bank, registered
- ff_r  out  NFF  R inputs to the bank, registered
- ff_q  in  NFF  Q outputs from the bank (readback)
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when a command completes
- err  out  2  sticky: [0] index out of range, [1] readback mismatch

## Operation
- States:
  - IDLE: arbitrate; on transfer, capture op/idx and go to ISSUE.
  - ISSUE: drive the pulse. Go to CHECK if the macro is defined, else back to IDLE.
  - CHECK: compare readback, then go to IDLE.
- Arbitration:
  - Round-robin. The search starts at last granted + 1, modulo NREQ; after reset it starts at requester 0.
  - The winner is the first requester with req_valid set.
  - req_ready is asserted only in IDLE and only to the winner; it is all-zero otherwise.
- Pulse generation:
  - In ISSUE, ff_s[idx] is 1 for op=1, or ff_r[idx] is 1 for op=0.
  - All other bits are 0.
  - Invariant: (ff_s & ff_r) == 0, and popcount(ff_s | ff_r) <= 1, in every cycle.
- Out-of-range index (idx >= NFF):
  - Command is accepted; no pulse is driven.
  - err[0] is set and done still pulses.
- Readback check (CHECK state):
  - If ff_q[idx] != op, set err[1].
  - Skipped for out-of-range commands.
- err bits clear only on rst.
- A requester that drops req_valid before being granted loses nothing; there is no pending state per requester.
- done pulses in the final state of each command: CHECK, or ISSUE when the macro is undefined.

## Timing
- Reset values: state IDLE, rr pointer 0, ff_s=0, ff_r=0, req_ready=0, busy=0, done=0, err=2'b00.
- Command timeline (macro defined):
  - Cycle 0 (IDLE): accept.
  - Cycle 1 (ISSUE): pulse; the bank captures at the end of cycle 1.
  - Cycle 2 (CHECK): ff_q is valid, done=1.
  - Cycle 3: IDLE again, next grant possible.
- Throughput: one command per 3 cycles with the macro, 2 without.
- Pulse width is exactly one clk cycle.
- Simultaneous valids: one grant per IDLE cycle. Losers keep req_valid asserted and are served in rotation; no requester waits more than NREQ-1 commands.
- rst mid-command: outputs drop to reset values immediately (asynchronously) and the in-flight command is lost. Requesters must reissue.

## Configuration
- SR_BANK_ARBITER_VERIFY_EN defined: CHECK state present; err[1] is active.
- Undefined: ISSUE returns directly to IDLE, err[1] is tied to 0, and ff_q is unused.

## Structure
- Package sr_bank_pkg:
  - state enum {IDLE, ISSUE, CHECK}
  - OP_SET=1'b1, OP_RESET=1'b0
  - ERR_RANGE=0, ERR_MISMATCH=1 bit positions
- Sub-module sr_rr_arbiter: takes the rr pointer and req_valid, and produces the one-hot grant and the winner index. Parameterized by NREQ.

## Test plan
- Reset, then requester 2 issues set idx=5 → req_ready=4'b0100 in the accept cycle; ff_s=8'h20 for one cycle; Q[5]=1; done at cycle 2.
- All four requesters valid continuously, each with a distinct idx → grant order 0,1,2,3,0 and S/R never both high, checked every cycle.
- Requester 1 sets idx=3, then resets idx=3 → ff_s=8'h08 pulse, then ff_r=8'h08 pulse; Q[3] reads 1 then 0; err stays 00.
- With NFF=6, requester 0 issues idx=7 → no pulse, err=2'b01, done pulses.
- Macro defined and the bench forces ff_q[4]=0 after a set to idx=4 → err[1]=1, held until rst.
- rst asserted during the ISSUE cycle → ff_s/ff_r drop to 0 before the next edge; after release, requester 0 has priority.

Source files
------------

// File: rtl/sr_bank_pkg.sv
// Shared types and constants for the SR flip-flop bank arbiter.
package sr_bank_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      CHECK = 2'd2
   } state_t;

   localparam logic OP_SET   = 1'b1;
   localparam logic OP_RESET = 1'b0;

   localparam int ERR_RANGE    = 0;
   localparam int ERR_MISMATCH = 1;

endpackage

// File: rtl/sr_rr_arbiter.sv
// Round-robin winner search: scans requesters starting at ptr, wrapping modulo NREQ.
module sr_rr_arbiter #(
   parameter int NREQ = 4,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [PW-1:0]   ptr,
   input  logic [NREQ-1:0] valid,
   output logic [NREQ-1:0] grant,
   output logic [PW-1:0]   win,
   output logic            any
);

   int unsigned k;

   always_comb begin
      grant = '0;
      win   = '0;
      any   = 1'b0;
      k     = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         k = (32'(ptr) + i) % NREQ;
         if (!any && valid[k]) begin
            any      = 1'b1;
            grant[k] = 1'b1;
            win      = PW'(k);
         end
      end
   end

endmodule

// File: rtl/sr_bank_arbiter.sv
// Round-robin arbiter turning set/reset commands into single-cycle S or R pulses on an SR bank.
// Optional readback verification enabled by defining SR_BANK_ARBITER_VERIFY_EN.
module sr_bank_arbiter
   import sr_bank_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int NFF  = 8,
   parameter int IDXW = $clog2(NFF)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ-1:0]      req_op,
   input  logic [NREQ*IDXW-1:0] req_idx,
   output logic [NREQ-1:0]      req_ready,
   output logic [NFF-1:0]       ff_s,
   output logic [NFF-1:0]       ff_r,
   input  logic [NFF-1:0]       ff_q,
   output logic                 busy,
   output logic                 done,
   output logic [1:0]           err
);

   localparam int PW = $clog2(NREQ);

   state_t          state, state_next;
   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   win;
   logic [NREQ-1:0] grant;
   logic            any;
   logic            transfer;
   logic            sel_op;
   logic [IDXW-1:0] sel_idx;
   logic            sel_ok;
   logic [NFF-1:0]  sel_vec;
   logic            range_err;
   logic            mismatch_err;

   sr_rr_arbiter #(
      .NREQ(NREQ),
      .PW  (PW)
   ) u_arb (
      .ptr  (rr_ptr),
      .valid(req_valid),
      .grant(grant),
      .win  (win),
      .any  (any)
   );

   assign transfer = (state == IDLE) && any;
   assign sel_op   = req_op[win];
   assign sel_idx  = req_idx[int'(win)*IDXW +: IDXW];
   assign sel_ok   = int'(sel_idx) < NFF;

   // Out-of-range targets leave the vector empty, so no pulse reaches the bank.
   always_comb begin
      sel_vec = '0;
      if (sel_ok) sel_vec[sel_idx] = 1'b1;
   end

   assign req_ready = (state == IDLE && !rst) ? grant : '0;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (transfer) state_next = ISSUE;
`ifdef SR_BANK_ARBITER_VERIFY_EN
         ISSUE: state_next = CHECK;
`else
         ISSUE: state_next = IDLE;
`endif
         CHECK: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Pulses are registered at the accept edge so they are high exactly during ISSUE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ff_s      <= '0;
         ff_r      <= '0;
         rr_ptr    <= '0;
         range_err <= 1'b0;
      end else begin
         ff_s <= '0;
         ff_r <= '0;
         if (transfer) begin
            rr_ptr <= (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
            if (sel_op == OP_SET) ff_s <= sel_vec;
            else                  ff_r <= sel_vec;
            if (!sel_ok) range_err <= 1'b1;
         end
      end
   end

`ifdef SR_BANK_ARBITER_VERIFY_EN
   logic            op_q;
   logic [IDXW-1:0] idx_q;
   logic            ok_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q         <= OP_RESET;
         idx_q        <= '0;
         ok_q         <= 1'b0;
         mismatch_err <= 1'b0;
      end else begin
         if (transfer) begin
            op_q  <= sel_op;
            idx_q <= sel_idx;
            ok_q  <= sel_ok;
         end
         if (state == CHECK && ok_q && ff_q[idx_q] != op_q) mismatch_err <= 1'b1;
      end
   end

   assign done = (state == CHECK);
`else
   logic unused_q;
   assign unused_q     = ^ff_q;
   assign mismatch_err = 1'b0;
   assign done         = (state == ISSUE);
`endif

   assign err[ERR_RANGE]    = range_err;
   assign err[ERR_MISMATCH] = mismatch_err;

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Directed self-checking bench for sr_bank_arbiter with a behavioural SR bank.
module tb_sr_bank_arbiter;

`ifdef SR_BANK_ARBITER_VERIFY_EN
   localparam logic MAC = 1'b1;
   localparam int   L   = 3;
`else
   localparam logic MAC = 1'b0;
   localparam int   L   = 2;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req_valid, req_op, req_ready;
   logic [11:0] req_idx;
   logic [7:0] ff_s, ff_r, ff_q;
   logic       busy, done;
   logic [1:0] err;

   logic [3:0] b_valid, b_op, b_ready;
   logic [11:0] b_idx;
   logic [5:0] b_s, b_r, b_q;
   logic       b_busy, b_done;
   logic [1:0] b_err;

   logic [7:0] bank_q, q_kill;
   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sr_bank_arbiter #(.NREQ(4), .NFF(8), .IDXW(3)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_idx(req_idx),
      .req_ready(req_ready), .ff_s(ff_s), .ff_r(ff_r), .ff_q(ff_q),
      .busy(busy), .done(done), .err(err)
   );

   sr_bank_arbiter #(.NREQ(4), .NFF(6), .IDXW(3)) dut6 (
      .clk(clk), .rst(rst), .req_valid(b_valid), .req_op(b_op), .req_idx(b_idx),
      .req_ready(b_ready), .ff_s(b_s), .ff_r(b_r), .ff_q(b_q),
      .busy(b_busy), .done(b_done), .err(b_err)
   );

   assign b_q = '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) bank_q <= '0;
      else     bank_q <= (bank_q | ff_s) & ~ff_r;
   end
   assign ff_q = bank_q & ~q_kill;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req_valid = '0;
      b_valid   = '0;
      rst       = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic check_inv(input string tag);
      check(tag, 32'(((ff_s & ff_r) == 8'h00) && ($countones(ff_s | ff_r) <= 1)), 32'd1);
   endtask

   task automatic cmd(input int r, input logic op, input logic [2:0] idx,
                      input logic [7:0] es, input logic [7:0] er);
      req_valid           = '0;
      req_valid[r]        = 1'b1;
      req_op[r]           = op;
      req_idx[r*3 +: 3]   = idx;
      #1;
      check("grant", 32'(req_ready), 32'(1) << r);
      step();
      req_valid = '0;
      check("pulse_s", 32'(ff_s), 32'(es));
      check("pulse_r", 32'(ff_r), 32'(er));
      check("issue_busy", 32'(busy), 32'd1);
      check("issue_done", 32'(done), MAC ? 32'd0 : 32'd1);
      check("issue_ready", 32'(req_ready), 32'd0);
      step();
      check("post_pulse", 32'(ff_s | ff_r), 32'd0);
`ifdef SR_BANK_ARBITER_VERIFY_EN
      check("check_done", 32'(done), 32'd1);
      step();
`endif
      check("idle_busy", 32'(busy), 32'd0);
   endtask

   task automatic rr_test();
      int g;
      req_op = 4'b0101;
      for (int k = 0; k < 4; k++) req_idx[k*3 +: 3] = 3'(2*k + 1);
      req_valid = 4'b1111;
      #1;
      for (int n = 0; n < 5; n++) begin
         g = n % 4;
         check("rr_grant", 32'(req_ready), 32'(1) << g);
         step();
         check("rr_s", 32'(ff_s), (g % 2 == 0) ? (32'(1) << (2*g + 1)) : 32'd0);
         check("rr_r", 32'(ff_r), (g % 2 == 1) ? (32'(1) << (2*g + 1)) : 32'd0);
         check_inv("rr_inv");
         for (int c = 1; c < L; c++) begin
            step();
            check_inv("rr_inv");
            check("rr_quiet", 32'(ff_s | ff_r), 32'd0);
         end
      end
      req_valid = '0;
      for (int c = 1; c < L; c++) step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      req_valid = '0; req_op = '0; req_idx = '0; q_kill = '0;
      b_valid = '0; b_op = '0; b_idx = '0;
      do_reset();

      check("rst_s", 32'(ff_s), 32'd0);
      check("rst_r", 32'(ff_r), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);

      // Out-of-range index on the 6-entry bank.
      b_valid = 4'b0001; b_op = 4'b0001; b_idx[2:0] = 3'd7;
      #1;
      check("oor_grant", 32'(b_ready), 32'd1);
      step();
      b_valid = '0;
      check("oor_s", 32'(b_s), 32'd0);
      check("oor_r", 32'(b_r), 32'd0);
      check("oor_err", 32'(b_err), 32'd1);
      check("oor_done_issue", 32'(b_done), MAC ? 32'd0 : 32'd1);
      step();
`ifdef SR_BANK_ARBITER_VERIFY_EN
      check("oor_done_check", 32'(b_done), 32'd1);
      step();
`endif
      check("oor_busy", 32'(b_busy), 32'd0);
      check("oor_err_hold", 32'(b_err), 32'd1);

      cmd(2, 1'b1, 3'd5, 8'h20, 8'h00);
      check("q5", 32'(ff_q[5]), 32'd1);

      cmd(1, 1'b1, 3'd3, 8'h08, 8'h00);
      check("q3_set", 32'(ff_q[3]), 32'd1);
      cmd(1, 1'b0, 3'd3, 8'h00, 8'h08);
      check("q3_reset", 32'(ff_q[3]), 32'd0);
      check("err_clean", 32'(err), 32'd0);

      do_reset();
      rr_test();

      // Reset during ISSUE: outputs clear at once, requester 0 first afterwards.
      req_op = 4'b1001; req_idx[11:9] = 3'd6; req_idx[2:0] = 3'd0;
      req_valid = 4'b1000;
      #1;
      check("mid_grant", 32'(req_ready), 32'h8);
      step();
      check("mid_s", 32'(ff_s), 32'h40);
      #1 rst = 1'b1;
      #1;
      check("mid_rst_s", 32'(ff_s), 32'd0);
      check("mid_rst_r", 32'(ff_r), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      req_valid = 4'b1001;
      #1 rst = 1'b0;
      #1;
      check("post_rst_grant", 32'(req_ready), 32'h1);
      step();
      req_valid = '0;
      check("post_rst_s", 32'(ff_s), 32'h01);
      for (int c = 1; c < L; c++) step();

`ifdef SR_BANK_ARBITER_VERIFY_EN
      do_reset();
      q_kill = 8'h10;
      cmd(0, 1'b1, 3'd4, 8'h10, 8'h00);
      check("mm_err", 32'(err), 32'h2);
      step();
      step();
      check("mm_err_hold", 32'(err), 32'h2);
      q_kill = 8'h00;
      do_reset();
      check("mm_err_rst", 32'(err), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
